// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and client identifiers.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_client_t;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cacheline_adaptor port between the I-cache and D-cache.
// One line transaction at a time, followed by a mandatory idle (DONE) cycle.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: ties go to the client not granted
// last; without it the D-cache always wins a tie.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q, state_d;
  logic       d_req;

  assign d_req = d_read | d_write;

  // Read data goes to both clients unconditionally; only *_resp qualifies it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_client_t last_grant_q, last_grant_d;

  // State and last-grant registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: round-robin tie-break, last grant recorded on every BUSY entry.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (d_req && i_read) begin
          if (last_grant_q == ARB_I) begin
            state_d      = D_BUSY;
            last_grant_d = ARB_D;
          end else begin
            state_d      = I_BUSY;
            last_grant_d = ARB_I;
          end
        end else if (d_req) begin
          state_d      = D_BUSY;
          last_grant_d = ARB_D;
        end else if (i_read) begin
          state_d      = I_BUSY;
          last_grant_d = ARB_I;
        end
      end
      I_BUSY:  if (pmem_resp) state_d = DONE;
      D_BUSY:  if (pmem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`else
  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed priority, D-cache wins every tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req)       state_d = D_BUSY;
        else if (i_read) state_d = I_BUSY;
      end
      I_BUSY:  if (pmem_resp) state_d = DONE;
      D_BUSY:  if (pmem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`endif

  // Port steering: strobes come from the registered state; IDLE/DONE drive all zeros.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_q)
      I_BUSY: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      D_BUSY: begin
        pmem_read    = d_read;
        pmem_write   = d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // The D-cache never asks for a fill and a write-back at once.
  a_no_d_read_write: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("mem_arbiter: d_read and d_write asserted together");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for the late-request and fairness cases. Honors MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_address, d_address, pmem_address;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] Z  = 256'h0;
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] WD = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] X1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] X2 = {16{16'h5A3C}};

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic         rst;
    logic         ir;
    logic [31:0]  ia;
    logic         dr;
    logic         dw;
    logic [31:0]  da;
    logic [255:0] dwd;
    logic [255:0] prd;
    logic         presp;
    logic         e_pr;
    logic         e_pw;
    logic [31:0]  e_pa;
    logic [255:0] e_pwd;
    logic         e_ir;
    logic         e_dr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [255:0] dwd, input logic [255:0] prd, input logic presp,
                     input logic e_pr, input logic e_pw, input logic [31:0] e_pa,
                     input logic [255:0] e_pwd, input logic e_ir, input logic e_dr);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.dwd = dwd; v.prd = prd; v.presp = presp;
    v.e_pr = e_pr; v.e_pw = e_pw; v.e_pa = e_pa; v.e_pwd = e_pwd;
    v.e_ir = e_ir; v.e_dr = e_dr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One cycle of the fairness sequence: returns which client (1=D, 0=I) was granted.
  task automatic fair_txn(input int t, output logic who);
    // IDLE cycle: both clients requesting
    @(negedge clk);
    i_read = 1'b1; d_read = 1'b1; pmem_resp = 1'b0;
    #1;
    chk($sformatf("t6_%0d_idle_pmem_read", t), {255'b0, pmem_read}, Z);
    // BUSY cycle
    @(negedge clk);
    #1;
    who = (pmem_address == 32'h0000_9000);
    chk($sformatf("t6_%0d_busy_pmem_read", t), {255'b0, pmem_read}, {255'b0, 1'b1});
    pmem_resp = 1'b1;
    #1;
    chk($sformatf("t6_%0d_i_resp", t), {255'b0, i_resp}, {255'b0, ~who});
    chk($sformatf("t6_%0d_d_resp", t), {255'b0, d_resp}, {255'b0, who});
    // DONE cycle: D drops its request only if it was just served
    @(negedge clk);
    pmem_resp = 1'b0;
    if (who) d_read = 1'b0;
    #1;
    chk($sformatf("t6_%0d_done_pmem_read", t), {255'b0, pmem_read}, Z);
  endtask

  initial begin
    logic who;
    logic exp_who;

    rst = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);

    //   rst ir ia            dr dw da            dwd prd presp | pr pw pa            pwd ir dr
    // reset state, pmem_resp ignored in IDLE
    add(1, 0, 32'h0,         0, 0, 32'h0,         Z,  Z,  1,     0, 0, 32'h0,         Z,  0, 0);
    // test 1: I only
    add(0, 1, 32'h0000_1000, 0, 0, 32'h0,         Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 1, 32'h0000_1000, 0, 0, 32'h0,         Z,  Z,  0,     1, 0, 32'h0000_1000, Z,  0, 0);
    add(0, 1, 32'h0000_1000, 0, 0, 32'h0,         Z,  A5, 1,     1, 0, 32'h0000_1000, Z,  1, 0);
    add(0, 1, 32'h0000_1000, 0, 0, 32'h0,         Z,  A5, 0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 0, 32'h0000_1000, 0, 0, 32'h0,         Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    // test 2: D write-back
    add(0, 0, 32'h0,         0, 1, 32'h0000_2040, WD, Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 0, 32'h0,         0, 1, 32'h0000_2040, WD, Z,  0,     0, 1, 32'h0000_2040, WD, 0, 0);
    add(0, 0, 32'h0,         0, 1, 32'h0000_2040, WD, X2, 1,     0, 1, 32'h0000_2040, WD, 0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0000_2040, WD, Z,  1,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         Z,  Z,  1,     0, 0, 32'h0,         Z,  0, 0);
    // test 3: tie from reset, D first, I after DONE+IDLE
    add(1, 0, 32'h0,         0, 0, 32'h0,         Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 1, 32'h0000_3000, 1, 0, 32'h0000_4000, Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 1, 32'h0000_3000, 1, 0, 32'h0000_4000, Z,  Z,  0,     1, 0, 32'h0000_4000, Z,  0, 0);
    add(0, 1, 32'h0000_3000, 1, 0, 32'h0000_4000, Z,  X1, 1,     1, 0, 32'h0000_4000, Z,  0, 1);
    add(0, 1, 32'h0000_3000, 0, 0, 32'h0,         Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 1, 32'h0000_3000, 0, 0, 32'h0,         Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 1, 32'h0000_3000, 0, 0, 32'h0,         Z,  Z,  0,     1, 0, 32'h0000_3000, Z,  0, 0);
    add(0, 1, 32'h0000_3000, 0, 0, 32'h0,         Z,  A5, 1,     1, 0, 32'h0000_3000, Z,  1, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    // test 5: reset mid-D_BUSY, late pmem_resp ignored
    add(0, 0, 32'h0,         1, 0, 32'h0000_5000, Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 0, 32'h0,         1, 0, 32'h0000_5000, Z,  Z,  0,     1, 0, 32'h0000_5000, Z,  0, 0);
    add(1, 0, 32'h0,         1, 0, 32'h0000_5000, Z,  Z,  0,     1, 0, 32'h0000_5000, Z,  0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0000_5000, Z,  X1, 1,     0, 0, 32'h0,         Z,  0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         Z,  Z,  0,     0, 0, 32'h0,         Z,  0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; i_read = vecs[k].ir; i_address = vecs[k].ia;
      d_read = vecs[k].dr; d_write = vecs[k].dw; d_address = vecs[k].da;
      d_wdata = vecs[k].dwd; pmem_rdata = vecs[k].prd; pmem_resp = vecs[k].presp;
      #1;
      chk($sformatf("r%0d_pmem_read", k),    {255'b0, pmem_read},    {255'b0, vecs[k].e_pr});
      chk($sformatf("r%0d_pmem_write", k),   {255'b0, pmem_write},   {255'b0, vecs[k].e_pw});
      chk($sformatf("r%0d_pmem_address", k), {224'b0, pmem_address}, {224'b0, vecs[k].e_pa});
      chk($sformatf("r%0d_pmem_wdata", k),   pmem_wdata,             vecs[k].e_pwd);
      chk($sformatf("r%0d_i_resp", k),       {255'b0, i_resp},       {255'b0, vecs[k].e_ir});
      chk($sformatf("r%0d_d_resp", k),       {255'b0, d_resp},       {255'b0, vecs[k].e_dr});
      chk($sformatf("r%0d_i_rdata", k),      i_rdata,                vecs[k].prd);
      chk($sformatf("r%0d_d_rdata", k),      d_rdata,                vecs[k].prd);
    end

    // test 4: D request raised 3 cycles into I_BUSY
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = Z; i_read = 1'b1; i_address = 32'h0000_6000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 3) begin d_read = 1'b1; d_address = 32'h0000_7000; end
      if (c == 4) begin pmem_resp = 1'b1; pmem_rdata = A5; end
      #1;
      chk($sformatf("t4_c%0d_pmem_address", c), {224'b0, pmem_address}, {224'b0, 32'h0000_6000});
      chk($sformatf("t4_c%0d_pmem_read", c), {255'b0, pmem_read}, {255'b0, 1'b1});
    end
    chk("t4_i_resp", {255'b0, i_resp}, {255'b0, 1'b1});
    chk("t4_d_resp", {255'b0, d_resp}, Z);
    @(negedge clk);
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    chk("t4_done_pmem_read", {255'b0, pmem_read}, Z);
    @(negedge clk);
    #1;
    chk("t4_idle_pmem_read", {255'b0, pmem_read}, Z);
    @(negedge clk);
    #1;
    chk("t4_d_pmem_address", {224'b0, pmem_address}, {224'b0, 32'h0000_7000});
    chk("t4_d_pmem_read", {255'b0, pmem_read}, {255'b0, 1'b1});
    pmem_resp = 1'b1;
    #1;
    chk("t4_d_resp_late", {255'b0, d_resp}, {255'b0, 1'b1});
    @(negedge clk);
    pmem_resp = 1'b0; d_read = 1'b0;

    // test 6: starvation / fairness, starting from reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_address = 32'h0000_8000; d_address = 32'h0000_9000;
    for (int t = 0; t < 5; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_who = (t % 2 == 0);
`else
      exp_who = 1'b1;
`endif
      fair_txn(t, who);
      chk($sformatf("t6_%0d_grant_is_d", t), {255'b0, who}, {255'b0, exp_who});
    end
    @(negedge clk);
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
